motor_step_ctrl: RTL and testbench
==================================

# motor_step_ctrl

- Receives the motor number and target coordinate latched by the front-panel entry block and moves that motor to the target.
- Generates STEP/DIR pulse trains for one of six stepper motors.
- Tracks the absolute position of each motor, raises Busy while a move runs and pulses Done when it finishes.
- Sits between the keypad entry logic and the motor driver pins.

## Interface
Parameters:
- STEP_DIV, 50000: sysclk cycles per step period; even, ≥4.
- N_MOTOR, 6: motors served; valid Motor codes are 0..N_MOTOR-1.
- POS_MAX, 999: largest legal coordinate.

Ports:
- sysclk  in  1  system clock; all logic on its rising edge.
- INIT_n  in  1  reset; synchronous and active-low.
- Start  in  1  one-cycle command strobe, asserted the cycle after Enter.
- Motor  in  4  target motor number.
- Value  in  10  target absolute coordinate.
- Step  out  N_MOTOR  step pulses, one bit per motor.
- Dir  out  N_MOTOR  direction per motor; 1 = increasing coordinate.
- Busy  out  1  a move is in progress.
- Done  out  1  one-cycle pulse when a move completes.
- Err  out  1  one-cycle pulse when a command is rejected.

## Operation
- Per-motor position registers Pos[0..N_MOTOR-1], 10 bits each, all reset to 0.
- State machine:
  - IDLE: waits for Start.
  - LOAD: latches the command and computes the move.
  - RUN: generates steps.
  - DONE: pulses Done, then returns to IDLE.
- IDLE, Start=1:
  - Motor ≥ N_MOTOR: Err=1 for the next cycle, stay in IDLE, no state change.
  - Otherwise latch Motor → m and Value → tgt, with Value > POS_MAX clamped to POS_MAX. Go to LOAD.
- LOAD:
  - rem = |tgt − Pos[m]|, 10-bit unsigned.
  - Dir[m] = (tgt > Pos[m]).
  - rem==0 → DONE; otherwise → RUN with divider cnt=0.
- RUN:
  - cnt counts 0..STEP_DIV−1.
  - Step[m] = 1 while cnt < STEP_DIV/2, else 0.
  - At cnt==STEP_DIV−1: Pos[m] ±1 per Dir[m], rem−1, cnt→0.
  - If rem reaches 0 on that edge → DONE.
- DONE: Done=1 for exactly one cycle, then → IDLE.
- Start outside IDLE is ignored: no Err, no queueing.
- Dir bits hold their last value between moves. Step bits of unselected motors stay 0.
- Pos never goes outside 0..POS_MAX, because rem is derived from a clamped target.

## Timing
- Reset (INIT_n=0 at a rising edge):
  - State=IDLE; Step=0, Dir=0, Busy=0, Done=0, Err=0.
  - All Pos=0; cnt=0, rem=0.
  - Reset mid-move aborts immediately: no Done, positions zeroed.
- Start sampled at edge t:
  - LOAD at t+1; Busy=1 from t+1.
  - First Step high at t+2.
  - For n steps, DONE at t+2+n·STEP_DIV. Done is high in that cycle and Busy is still 1.
  - Busy=0 from the next cycle.
- Zero-length move: DONE at t+2, Busy high for 2 cycles.
- Dir is stable ≥1 cycle before the first Step rising edge; the LOAD cycle provides the setup.
- Err pulses at t+1 for a rejected command; Busy stays 0.

## Configuration
- POS_READBACK_EN
  - Defined: adds output port Cur_Pos[9:0] = Pos[Motor] (combinational from the Motor input), for LCD display of the current coordinate. Motor ≥ N_MOTOR reads 0.
  - Undefined: the port and its mux are absent; behaviour is otherwise identical.

## Structure
- Shared package: state encoding (IDLE/LOAD/RUN/DONE), constants N_MOTOR=6 and POS_MAX=999, the 10-bit coordinate typedef. The keypad entry block uses the same limits.
- One sub-module, step_divider:
  - Contains cnt, the Step-high compare and a terminal-count pulse.
  - Inputs: enable and clear.
- The top level holds the FSM, the Pos array and the Dir/Step demux.

## Test plan
All scenarios use STEP_DIV=4.
- Basic move: reset; Start, Motor=2, Value=5 at t.
  - Dir[2]=1 by t+1.
  - Five Step[2] pulses, each 2 high / 2 low, t+2..t+21.
  - Done at t+22, Busy 0 at t+23; Pos[2]=5.
- Reverse move: from Pos[2]=5, Start Motor=2, Value=3 → Dir[2]=0, two pulses, Pos[2]=3, Done at t+10.
- Zero move and clamp:
  - Motor=1, Value=0 from 0 → no Step, Done at t+2.
  - Then Value=1023 → 999 steps, Pos[1]=999.
- Reject and ignore:
  - Motor=7 → Err at t+1, Busy stays 0.
  - Start during RUN → no effect; the move count is unchanged.
- Reset mid-move: INIT_n=0 during the 3rd step of Motor 4 → all outputs 0 next cycle, no Done, all Pos=0.
- POS_READBACK_EN defined: after Motor=3 moves to 12, Cur_Pos=12 with Motor=3 and 0 with Motor=0.

Source files
------------

// File: rtl/motor_step_ctrl_pkg.sv
// Shared definitions for the stepper motor move controller and the keypad
// entry logic: motor/coordinate limits, coordinate type, FSM state encoding
// and small coordinate arithmetic helpers.
package motor_step_ctrl_pkg;

  localparam int N_MOTOR_DEF = 6;
  localparam int POS_MAX_DEF = 999;
  localparam int COORD_W     = 10;
  localparam int MOTOR_W     = 4;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [MOTOR_W-1:0] motor_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Saturate a keypad coordinate to the largest legal position.
  function automatic coord_t clamp_coord(input coord_t v, input coord_t lim);
    coord_t r;
    if (v > lim) begin
      r = lim;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Unsigned distance between two coordinates.
  function automatic coord_t abs_diff(input coord_t a, input coord_t b);
    coord_t r;
    if (a > b) begin
      r = a - b;
    end else begin
      r = b - a;
    end
    return r;
  endfunction

endpackage

// File: rtl/motor_step_ctrl_if.sv
// Command/status bus between the keypad entry block (master) and the
// move controller (slave).
interface motor_step_ctrl_if;
  import motor_step_ctrl_pkg::*;

  logic   Start;
  motor_t Motor;
  coord_t Value;
  logic   Busy;
  logic   Done;
  logic   Err;

  modport master (
    output Start, Motor, Value,
    input  Busy, Done, Err
  );

  modport slave (
    input  Start, Motor, Value,
    output Busy, Done, Err
  );

endinterface

// File: rtl/motor_step_ctrl_step_divider.sv
// Step-period divider: counts 0..STEP_DIV-1 while enabled, reports whether
// the upcoming count lies in the high half of the step period and pulses a
// terminal count on the last cycle of each period.
module motor_step_ctrl_step_divider #(
  parameter int STEP_DIV = 50000
) (
  input  logic sysclk,
  input  logic INIT_n,
  input  logic enable,
  input  logic clear,
  output logic step_hi_nxt,
  output logic tc
);

  localparam int CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(STEP_DIV / 2);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  // Next count, the step-high decode of that count and the period terminal count.
  always_comb begin
    cnt_nxt_s = cnt_r;
    tc        = 1'b0;
    if (clear) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (enable) begin
      if (cnt_r == CNT_LAST) begin
        cnt_nxt_s = CNT_ZERO;
        tc        = 1'b1;
      end else begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
    step_hi_nxt = (cnt_nxt_s < CNT_HALF);
  end

  // Divider count register.
  always_ff @(posedge sysclk) begin
    if (!INIT_n) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_nxt_s;
    end
  end

endmodule

// File: rtl/motor_step_ctrl.sv
// Stepper move controller: takes a (motor, target) command from the keypad
// entry block, drives STEP/DIR for the selected motor until its tracked
// absolute position reaches the clamped target, then pulses Done.
// Optional feature macro: POS_READBACK_EN adds the Cur_Pos readback port.
module motor_step_ctrl
  import motor_step_ctrl_pkg::*;
#(
  parameter int STEP_DIV = 50000,
  parameter int N_MOTOR  = N_MOTOR_DEF,
  parameter int POS_MAX  = POS_MAX_DEF
) (
  input  logic               sysclk,
  input  logic               INIT_n,
  motor_step_ctrl_if.slave   cmd,
  output logic [N_MOTOR-1:0] Step,
  output logic [N_MOTOR-1:0] Dir
`ifdef POS_READBACK_EN
  ,
  output coord_t             Cur_Pos
`endif
);

  localparam int     MIDX_W     = (N_MOTOR > 1) ? $clog2(N_MOTOR) : 1;
  localparam motor_t N_MOTOR_L  = motor_t'(N_MOTOR);
  localparam coord_t POS_MAX_L  = coord_t'(POS_MAX);
  localparam coord_t COORD_ZERO = {COORD_W{1'b0}};
  localparam coord_t COORD_ONE  = coord_t'(1);

  state_e              state_r;
  state_e              state_nxt_s;
  logic [MIDX_W-1:0]   m_r;
  coord_t              tgt_r;
  coord_t              rem_r;
  coord_t              pos_r [N_MOTOR];

  logic [MIDX_W-1:0]   in_idx_s;
  logic                motor_bad_s;
  coord_t              val_clamped_s;
  coord_t              pos_in_s;
  coord_t              pos_m_s;
  coord_t              rem_ld_s;
  logic                accept_s;
  logic                reject_s;
  logic                div_en_s;
  logic                step_hi_nxt_s;
  logic                tc_s;
  logic [N_MOTOR-1:0]  step_nxt_s;

  assign div_en_s = (state_r == ST_RUN);

  motor_step_ctrl_step_divider #(
    .STEP_DIV (STEP_DIV)
  ) u_div (
    .sysclk      (sysclk),
    .INIT_n      (INIT_n),
    .enable      (div_en_s),
    .clear       (!div_en_s),
    .step_hi_nxt (step_hi_nxt_s),
    .tc          (tc_s)
  );

  // Command decode and move-length arithmetic.
  always_comb begin
    in_idx_s      = cmd.Motor[MIDX_W-1:0];
    motor_bad_s   = (cmd.Motor >= N_MOTOR_L);
    val_clamped_s = clamp_coord(cmd.Value, POS_MAX_L);
    pos_in_s      = pos_r[in_idx_s];
    pos_m_s       = pos_r[m_r];
    rem_ld_s      = abs_diff(tgt_r, pos_m_s);
  end

  // Next-state logic; Start is only looked at in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    reject_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd.Start) begin
          if (motor_bad_s) begin
            reject_s = 1'b1;
          end else begin
            accept_s    = 1'b1;
            state_nxt_s = ST_LOAD;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (rem_ld_s == COORD_ZERO) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tc_s && (rem_r == COORD_ONE)) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Step demux: only the selected motor pulses, and only while running.
  always_comb begin
    step_nxt_s = {N_MOTOR{1'b0}};
    if ((state_nxt_s == ST_RUN) && step_hi_nxt_s) begin
      step_nxt_s[m_r] = 1'b1;
    end else begin
      step_nxt_s = {N_MOTOR{1'b0}};
    end
  end

  // FSM state register.
  always_ff @(posedge sysclk) begin
    if (!INIT_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered status and step outputs, decoded from the next state.
  always_ff @(posedge sysclk) begin
    if (!INIT_n) begin
      cmd.Busy <= 1'b0;
      cmd.Done <= 1'b0;
      cmd.Err  <= 1'b0;
      Step     <= {N_MOTOR{1'b0}};
    end else begin
      cmd.Busy <= (state_nxt_s != ST_IDLE);
      cmd.Done <= (state_nxt_s == ST_DONE);
      cmd.Err  <= reject_s;
      Step     <= step_nxt_s;
    end
  end

  // Command latch, remaining steps, positions and direction. Dir is set when
  // the command is accepted so the LOAD cycle gives it setup before the first step.
  always_ff @(posedge sysclk) begin
    if (!INIT_n) begin
      m_r   <= {MIDX_W{1'b0}};
      tgt_r <= COORD_ZERO;
      rem_r <= COORD_ZERO;
      Dir   <= {N_MOTOR{1'b0}};
      for (int i = 0; i < N_MOTOR; i++) begin
        pos_r[i] <= COORD_ZERO;
      end
    end else begin
      if (accept_s) begin
        m_r           <= in_idx_s;
        tgt_r         <= val_clamped_s;
        Dir[in_idx_s] <= (val_clamped_s > pos_in_s);
      end
      if (state_r == ST_LOAD) begin
        rem_r <= rem_ld_s;
      end else if (tc_s) begin
        rem_r <= rem_r - COORD_ONE;
        if (Dir[m_r]) begin
          pos_r[m_r] <= pos_m_s + COORD_ONE;
        end else begin
          pos_r[m_r] <= pos_m_s - COORD_ONE;
        end
      end
    end
  end

`ifdef POS_READBACK_EN
  // Live position readback for the display, selected by the Motor input.
  always_comb begin
    if (motor_bad_s) begin
      Cur_Pos = COORD_ZERO;
    end else begin
      Cur_Pos = pos_in_s;
    end
  end
`endif

endmodule

// File: tb/tb_motor_step_ctrl.sv
// Self-checking bench for motor_step_ctrl (STEP_DIV=4): a table of hand-computed
// commands, random commands checked against a position model, and sequences
// for Start-while-busy and reset in the middle of a move.
module tb_motor_step_ctrl;
  import motor_step_ctrl_pkg::*;

  localparam int DIV  = 4;
  localparam int NM   = 6;
  localparam int PMAX = 999;

  typedef struct {
    int motor;
    int value;
    bit exp_err;
    int exp_n;
    bit exp_dir;
    int exp_done;
    int exp_pos;
  } cmd_t;

  logic          sysclk = 1'b0;
  logic          INIT_n;
  logic [NM-1:0] step;
  logic [NM-1:0] dir;
`ifdef POS_READBACK_EN
  coord_t        cur_pos;
`endif

  motor_step_ctrl_if bus();

  int            n_checks = 0;
  int            n_fail   = 0;
  int            mpos [NM];
  int            obs_pos [NM];
  logic [NM-1:0] exp_dir_vec;
  cmd_t          tbl [10];

  motor_step_ctrl #(
    .STEP_DIV (DIV),
    .N_MOTOR  (NM),
    .POS_MAX  (PMAX)
  ) dut (
    .sysclk  (sysclk),
    .INIT_n  (INIT_n),
    .cmd     (bus),
    .Step    (step),
    .Dir     (dir)
`ifdef POS_READBACK_EN
    ,
    .Cur_Pos (cur_pos)
`endif
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Expected outcome of a command from the position model and the move rules.
  function automatic cmd_t model_cmd(input int motor, input int value);
    cmd_t c;
    int   tgt;
    c.motor = motor;
    c.value = value;
    if (motor >= NM) begin
      c.exp_err = 1'b1; c.exp_n = 0; c.exp_dir = 1'b0; c.exp_done = 0; c.exp_pos = 0;
    end else begin
      tgt       = (value > PMAX) ? PMAX : value;
      c.exp_err = 1'b0;
      c.exp_dir = (tgt > mpos[motor]);
      c.exp_n   = (tgt > mpos[motor]) ? tgt - mpos[motor] : mpos[motor] - tgt;
      c.exp_done = 2 + DIV * c.exp_n;
      c.exp_pos = tgt;
    end
    return c;
  endfunction

  // Issue one command and check every cycle of its response; optionally
  // strobe Start again (inj_k cycles after acceptance) to confirm it is ignored.
  task automatic run_cmd(input string tag, input cmd_t c, input int inj_k, input int inj_motor);
    int            last;
    int            bad_step, bad_busy, bad_done, bad_err, bad_dir, rises;
    logic [NM-1:0] prev_step;
    logic [NM-1:0] exp_step;
    bit            exp_bit;
    bad_step = 0; bad_busy = 0; bad_done = 0; bad_err = 0; bad_dir = 0; rises = 0;
    if (!c.exp_err) exp_dir_vec[c.motor] = c.exp_dir;
    last = c.exp_err ? 3 : c.exp_done + 2;
    @(negedge sysclk);
    bus.Start = 1'b1;
    bus.Motor = 4'(c.motor);
    bus.Value = 10'(c.value);
    prev_step = step;
    for (int k = 1; k <= last; k++) begin
      @(negedge sysclk);
      bus.Start = 1'b0;
      exp_bit  = !c.exp_err && (k >= 2) && (k < 2 + DIV * c.exp_n) && (((k - 2) % DIV) < DIV / 2);
      exp_step = {NM{1'b0}};
      if (exp_bit) exp_step[c.motor] = 1'b1;
      if (step !== exp_step) bad_step++;
      if (bus.Busy !== (!c.exp_err && (k <= c.exp_done))) bad_busy++;
      if (bus.Done !== (!c.exp_err && (k == c.exp_done))) bad_done++;
      if (bus.Err !== (c.exp_err && (k == 1))) bad_err++;
      if (dir !== exp_dir_vec) bad_dir++;
      for (int i = 0; i < NM; i++) begin
        if (step[i] && !prev_step[i]) begin
          obs_pos[i] += dir[i] ? 1 : -1;
          if (i == c.motor) rises++;
        end
      end
      prev_step = step;
      if (k == inj_k) begin
        bus.Start = 1'b1;
        bus.Motor = 4'(inj_motor);
        bus.Value = 10'd0;
      end
    end
    check({tag, " step_pattern"}, bad_step, 0);
    check({tag, " busy"}, bad_busy, 0);
    check({tag, " done"}, bad_done, 0);
    check({tag, " err"}, bad_err, 0);
    check({tag, " dir"}, bad_dir, 0);
    if (!c.exp_err) begin
      check({tag, " step_count"}, rises, c.exp_n);
      check({tag, " pos"}, obs_pos[c.motor], c.exp_pos);
      mpos[c.motor] = c.exp_pos;
    end
  endtask

  initial begin
    int   mot, val, dsum, bsum;
    cmd_t c;

    // motor, value, err, steps, dir, done cycle, final position
    tbl[0] = '{2,    5, 1'b0,   5, 1'b1,   22,   5};
    tbl[1] = '{2,    3, 1'b0,   2, 1'b0,   10,   3};
    tbl[2] = '{1,    0, 1'b0,   0, 1'b0,    2,   0};
    tbl[3] = '{1, 1023, 1'b0, 999, 1'b1, 3998, 999};
    tbl[4] = '{7,   10, 1'b1,   0, 1'b0,    0,   0};
    tbl[5] = '{6,    0, 1'b1,   0, 1'b0,    0,   0};
    tbl[6] = '{3,   12, 1'b0,  12, 1'b1,   50,  12};
    tbl[7] = '{15, 1023, 1'b1,  0, 1'b0,    0,   0};
    tbl[8] = '{1,  999, 1'b0,   0, 1'b0,    2, 999};
    tbl[9] = '{0,    1, 1'b0,   1, 1'b1,    6,   1};

    for (int i = 0; i < NM; i++) begin
      mpos[i] = 0;
      obs_pos[i] = 0;
    end
    exp_dir_vec = {NM{1'b0}};

    INIT_n    = 1'b0;
    bus.Start = 1'b0;
    bus.Motor = 4'd0;
    bus.Value = 10'd0;
    repeat (3) @(negedge sysclk);
    check("reset step", int'(step), 0);
    check("reset dir", int'(dir), 0);
    check("reset busy", int'(bus.Busy), 0);
    check("reset done", int'(bus.Done), 0);
    check("reset err", int'(bus.Err), 0);
    INIT_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_cmd($sformatf("tbl%0d", i), tbl[i], 0, 0);
    end

`ifdef POS_READBACK_EN
    @(negedge sysclk);
    bus.Motor = 4'd3;
    #1 check("readback m3", int'(cur_pos), 12);
    bus.Motor = 4'd2;
    #1 check("readback m2", int'(cur_pos), 3);
    bus.Motor = 4'd7;
    #1 check("readback m7", int'(cur_pos), 0);
`endif

    // Start while running is ignored, valid or invalid motor.
    run_cmd("ignore_valid", model_cmd(0, 8), 5, 0);
    run_cmd("ignore_badmotor", model_cmd(0, 2), 6, 9);

    for (int r = 0; r < 30; r++) begin
      mot = int'($urandom_range(0, 7));
      if (mot < NM) val = mpos[mot] + int'($urandom_range(0, 30)) - 15;
      else val = int'($urandom_range(0, 1023));
      if (val < 0) val = 0;
      if (val > 1023) val = 1023;
      run_cmd($sformatf("rand%0d", r), model_cmd(mot, val), 0, 0);
    end

    // Reset during the third step pulse of a motor 4 move.
    c = model_cmd(4, (mpos[4] < 500) ? mpos[4] + 10 : mpos[4] - 10);
    @(negedge sysclk);
    bus.Start = 1'b1;
    bus.Motor = 4'd4;
    bus.Value = 10'(c.value);
    for (int k = 1; k <= 11; k++) begin
      @(negedge sysclk);
      bus.Start = 1'b0;
    end
    check("midmove step4 high", int'(step[4]), 1);
    INIT_n = 1'b0;
    @(negedge sysclk);
    check("midreset step", int'(step), 0);
    check("midreset dir", int'(dir), 0);
    check("midreset busy", int'(bus.Busy), 0);
    check("midreset done", int'(bus.Done), 0);
    check("midreset err", int'(bus.Err), 0);
    INIT_n = 1'b1;
    dsum = 0;
    bsum = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge sysclk);
      dsum += int'(bus.Done);
      bsum += int'(bus.Busy);
    end
    check("midreset no_done", dsum, 0);
    check("midreset no_busy", bsum, 0);
    for (int i = 0; i < NM; i++) begin
      mpos[i] = 0;
      obs_pos[i] = 0;
    end
    exp_dir_vec = {NM{1'b0}};
    run_cmd("post_reset", model_cmd(2, 3), 0, 0);
    run_cmd("post_reset4", model_cmd(4, 2), 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
